// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-PC operation codes and fetch FSM states.
package mips_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-unit bus bundle: instruction-memory handshake plus decode-side handoff.
interface ifetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  npc_op;
    logic [25:0] npc_imm;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready, npc_op, npc_imm
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready, npc_op, npc_imm
    );

endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC: sequential, PC-relative branch, or region jump.
module npc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic [25:0] npc_imm,
    output logic [31:0] npc
);

    logic [31:0] p4;
    logic [31:0] boff;

    assign p4   = pc + 32'd4;
    assign boff = {{14{npc_imm[15]}}, npc_imm[15:0], 2'b00};

    always_comb begin
        npc = p4;
        case (npc_op)
            NPC_BRANCH: npc = p4 + boff;
            NPC_JUMP:   npc = {p4[31:28], npc_imm, 2'b00};
            default:    npc = p4;
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// Non-pipelined instruction fetch: one request in flight, hands one
// instruction at a time to decode and advances the PC on accept.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        halt,
    ifetch_if.master    bus,
    output logic [31:0] retire_cnt
);

    fetch_state_t state;
    fetch_state_t state_nx;

    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        capture;
    logic        accept;

    npc_calc u_npc (
        .pc      (pc),
        .npc_op  (bus.npc_op),
        .npc_imm (bus.npc_imm),
        .npc     (npc)
    );

    // rstn gates the request so nothing leaks out while reset is held
    always_comb begin
        state_nx       = state;
        bus.imem_req   = 1'b0;
        bus.inst_valid = 1'b0;
        capture        = 1'b0;
        accept         = 1'b0;
        unique case (state)
            S_REQ: begin
                bus.imem_req = ~halt & rstn;
                if (bus.imem_gnt && !halt)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    capture  = 1'b1;
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                bus.inst_valid = 1'b1;
                if (bus.inst_ready) begin
                    accept   = 1'b1;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_REQ;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc         <= RESET_PC;
            retire_cnt <= 32'd0;
        end else if (accept) begin
            pc         <= npc;
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inst_q    <= 32'd0;
            inst_pc_q <= RESET_PC;
        end else if (capture) begin
            inst_q    <= bus.imem_rdata;
            inst_pc_q <= pc;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.inst      = inst_q;
    assign bus.inst_pc   = inst_pc_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: memory/decode stubs driven per scenario,
// expected PC and retire count from an arithmetic reference model.
module tb_ifetch;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        halt;
    logic [31:0] retire_cnt;

    ifetch_if bus();

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .halt       (halt),
        .bus        (bus),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] pc_m;
    logic [31:0] ret_m;

    function automatic logic [31:0] ref_npc(input logic [31:0] pc,
                                            input logic [1:0]  op,
                                            input logic [25:0] imm);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(imm[15:0])) * 4;
        case (op)
            2'd1:    return seq + 32'(off);
            2'd2:    return (seq & 32'hF000_0000) | (32'(imm) << 2);
            default: return seq;
        endcase
    endfunction

    task automatic set_pc(input logic [31:0] v);
        force dut.pc = v;
        #1;
        release dut.pc;
        pc_m = v;
    endtask

    task automatic do_fetch(input int gd, input int rd, input int ad,
                            input logic [31:0] word,
                            input logic [1:0]  op,
                            input logic [25:0] imm);
        int w;
        w = 0;
        while (bus.imem_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_chk++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc_m) begin
            n_fail++;
            $display("FAIL fetch_req: req=%b addr=%h, expected req=1 addr=%h",
                     bus.imem_req, bus.imem_addr, pc_m);
        end
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc_m) begin
                n_fail++;
                $display("FAIL req_hold: req=%b addr=%h, expected req=1 addr=%h",
                         bus.imem_req, bus.imem_addr, pc_m);
            end
        end
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        n_chk++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_state: req=%b valid=%b, expected 0 0",
                     bus.imem_req, bus.inst_valid);
        end
        for (int i = 0; i < rd; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold: req=%b valid=%b, expected 0 0",
                         bus.imem_req, bus.inst_valid);
            end
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        n_chk++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== word ||
            bus.inst_pc !== pc_m) begin
            n_fail++;
            $display("FAIL inst_out: valid=%b inst=%h pc=%h, expected 1 %h %h",
                     bus.inst_valid, bus.inst, bus.inst_pc, word, pc_m);
        end
        for (int i = 0; i < ad; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.inst_valid !== 1'b1 || bus.inst !== word ||
                retire_cnt !== ret_m || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL inst_hold: valid=%b inst=%h ret=%0d req=%b, expected 1 %h %0d 0",
                         bus.inst_valid, bus.inst, retire_cnt, bus.imem_req,
                         word, ret_m);
            end
        end
        bus.inst_ready = 1'b1;
        bus.npc_op     = op;
        bus.npc_imm    = imm;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        bus.npc_op     = 2'($urandom);
        bus.npc_imm    = 26'($urandom);
        ret_m = ret_m + 32'd1;
        pc_m  = ref_npc(pc_m, op, imm);
        n_chk++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== ~halt ||
            bus.imem_addr !== pc_m || retire_cnt !== ret_m) begin
            n_fail++;
            $display("FAIL accept: valid=%b req=%b addr=%h ret=%0d, expected 0 %b %h %0d",
                     bus.inst_valid, bus.imem_req, bus.imem_addr, retire_cnt,
                     ~halt, pc_m, ret_m);
        end
    endtask

    task automatic test_reset();
        rstn            = 1'b0;
        halt            = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.inst_ready  = 1'b0;
        bus.npc_op      = 2'd0;
        bus.npc_imm     = 26'd0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 ||
            bus.inst !== 32'd0 || bus.inst_pc !== 32'd0 ||
            retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h ret=%0d, expected 0 0 0 0 0",
                     bus.imem_req, bus.inst_valid, bus.inst, bus.inst_pc,
                     retire_cnt);
        end
        rstn  = 1'b1;
        pc_m  = 32'd0;
        ret_m = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_fetch(0, 0, 0, 32'h2008_0005, NPC_PLUS4, 26'd0);
    endtask

    task automatic test_branch();
        do_fetch(0, 0, 0, $urandom, NPC_JUMP, 26'h000_0004);
        do_fetch(0, 0, 0, $urandom, NPC_BRANCH, 26'h000_FFFC);
        do_fetch(0, 0, 0, $urandom, NPC_JUMP, 26'h000_0004);
        do_fetch(0, 0, 0, $urandom, NPC_BRANCH, 26'h000_0003);
    endtask

    task automatic test_halt();
        halt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.imem_gnt = i[0];
            @(negedge clk);
            n_chk++;
            if (bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_req: req=%b, expected 0", bus.imem_req);
            end
        end
        bus.imem_gnt = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc_m) begin
            n_fail++;
            $display("FAIL halt_resume: req=%b addr=%h, expected 1 %h",
                     bus.imem_req, bus.imem_addr, pc_m);
        end
        do_fetch(1, 0, 0, $urandom, NPC_PLUS4, 26'd0);
    endtask

    task automatic test_jump();
        set_pc(32'h1000_0000);
        do_fetch(0, 0, 0, $urandom, NPC_JUMP, 26'h000_0040);
        set_pc(32'h1000_0000);
        do_fetch(0, 0, 0, $urandom, 2'b11, 26'h3FF_FFFF);
    endtask

    task automatic test_boundary();
        set_pc(32'h0FFF_FFFC);
        do_fetch(0, 0, 0, $urandom, NPC_JUMP, 26'h3FF_FFFF);
        set_pc(32'h0000_0000);
        do_fetch(0, 0, 0, $urandom, NPC_BRANCH, 26'h000_8000);
        set_pc(32'hFFFF_FFFC);
        do_fetch(0, 0, 0, $urandom, NPC_PLUS4, 26'd0);
    endtask

    task automatic test_stall();
        do_fetch(5, 3, 4, $urandom, NPC_PLUS4, 26'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom, 2'($urandom),
                     26'($urandom));
    endtask

    task automatic test_reset_mid();
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt = 1'b0;
        #2 rstn = 1'b0;
        #1;
        n_chk++;
        if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0 ||
            retire_cnt !== 32'd0 || bus.imem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: req=%b valid=%b ret=%0d addr=%h, expected 0 0 0 0",
                     bus.imem_req, bus.inst_valid, retire_cnt, bus.imem_addr);
        end
        @(negedge clk);
        rstn            = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        pc_m  = 32'd0;
        ret_m = 32'd0;
        n_chk++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0 ||
            bus.inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_rvalid: req=%b addr=%h valid=%b, expected 1 0 0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid);
        end
        do_fetch(0, 1, 0, 32'h1234_5678, NPC_PLUS4, 26'd0);
    endtask

    task automatic test_wrap();
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        ret_m = 32'hFFFF_FFFF;
        do_fetch(0, 0, 0, $urandom, NPC_PLUS4, 26'd0);
        n_chk++;
        if (retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL retire_wrap: ret=%h, expected 0", retire_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_halt();
        test_jump();
        test_boundary();
        test_stall();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
